// File: rtl/openram_scan_sram_ctrl_if.sv
// ----------------------------------------------------------------------------
// openram_scan_sram_ctrl_if
//   SRAM bus shared between the scan-chain controller and the OpenRAM macros.
//   Address, data, write enable and byte mask are common to all macros. Each
//   macro has its own chip-select bit on each port. Read data from all macros
//   arrives flattened, with macro k at [k*DW +: DW].
//   master : the controller; drives selects, address, data, enables.
//   slave  : the macro array; returns dout0/dout1.
// ----------------------------------------------------------------------------
interface openram_scan_sram_ctrl_if #(
  parameter int NUM_SRAMS = 16,
  parameter int DW        = 32,
  parameter int AW        = 16
);
  logic [NUM_SRAMS-1:0]    sram_csb0;
  logic [NUM_SRAMS-1:0]    sram_csb1;
  logic                    sram_web0;
  logic                    sram_web1;
  logic [3:0]              sram_wmask0;
  logic [3:0]              sram_wmask1;
  logic [AW-1:0]           sram_addr0;
  logic [AW-1:0]           sram_addr1;
  logic [DW-1:0]           sram_din0;
  logic [DW-1:0]           sram_din1;
  logic [NUM_SRAMS*DW-1:0] sram_dout0;
  logic [NUM_SRAMS*DW-1:0] sram_dout1;

  modport master (
    output sram_csb0, sram_csb1, sram_web0, sram_web1,
           sram_wmask0, sram_wmask1, sram_addr0, sram_addr1,
           sram_din0, sram_din1,
    input  sram_dout0, sram_dout1
  );

  modport slave (
    input  sram_csb0, sram_csb1, sram_web0, sram_web1,
           sram_wmask0, sram_wmask1, sram_addr0, sram_addr1,
           sram_din0, sram_din1,
    output sram_dout0, sram_dout1
  );
endinterface

// File: rtl/openram_scan_sram_ctrl.sv
// ----------------------------------------------------------------------------
// openram_scan_sram_ctrl
//   GPIO-driven scan-chain controller for the OpenRAM test chip. A 112-bit
//   serial register is shifted in from a pad. It launches one SRAM access on
//   the selected macro, captures the read data, and shifts it back out.
//
//   Ports
//     clock      : sole clock; all state changes on the rising edge
//     reset      : synchronous, active-high
//     scan_en    : shift the scan register one bit per cycle
//     scan_in    : serial data in; enters at the LSB
//     scan_out   : serial data out; MSB of the scan register
//     sram_load  : copy the captured read data into the din fields
//     global_csb : active-low launch strobe for the SRAM access
//     sram       : SRAM bus (master side), see openram_scan_sram_ctrl_if
//
//   Scan register fields, MSB first:
//     sel[111:108] addr0[107:92] din0[91:60] csb0[59] web0[58] wmask0[57:54]
//     addr1[53:38] din1[37:6] csb1[5] web1[4] wmask1[3:0]
// ----------------------------------------------------------------------------
module openram_scan_sram_ctrl #(
  parameter int NUM_SRAMS = 16,
  parameter int DW        = 32,
  parameter int AW        = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic scan_en,
  input  logic scan_in,
  output logic scan_out,
  input  logic sram_load,
  input  logic global_csb,
  openram_scan_sram_ctrl_if.master sram
);

  // Field positions, counted from the LSB of the scan register
  localparam int SEL_W     = 4;
  localparam int WM1_LSB   = 0;
  localparam int WEB1_BIT  = WM1_LSB + 4;
  localparam int CSB1_BIT  = WEB1_BIT + 1;
  localparam int DIN1_LSB  = CSB1_BIT + 1;
  localparam int ADDR1_LSB = DIN1_LSB + DW;
  localparam int WM0_LSB   = ADDR1_LSB + AW;
  localparam int WEB0_BIT  = WM0_LSB + 4;
  localparam int CSB0_BIT  = WEB0_BIT + 1;
  localparam int DIN0_LSB  = CSB0_BIT + 1;
  localparam int ADDR0_LSB = DIN0_LSB + DW;
  localparam int SEL_LSB   = ADDR0_LSB + AW;
  localparam int SR_W      = SEL_LSB + SEL_W;

  logic [SR_W-1:0]      scanReg_q, scanReg_d;
  logic [SEL_W-1:0]     sel, sel_q;
  logic                 csb0Field, csb1Field, web0Field, web1Field;
  logic                 launched_q, rd0Pend_q, rd1Pend_q;
  logic [DW-1:0]        dout0_q, dout1_q;
  logic [DW-1:0]        rdData0, rdData1;
  logic [NUM_SRAMS-1:0] csb0Vec, csb1Vec;

  assign sel       = scanReg_q[SEL_LSB +: SEL_W];
  assign csb0Field = scanReg_q[CSB0_BIT];
  assign csb1Field = scanReg_q[CSB1_BIT];
  assign web0Field = scanReg_q[WEB0_BIT];
  assign web1Field = scanReg_q[WEB1_BIT];
  assign scan_out  = scanReg_q[SR_W-1];

  // The SRAM bus is driven directly from the scan register fields.
  assign sram.sram_addr0  = scanReg_q[ADDR0_LSB +: AW];
  assign sram.sram_din0   = scanReg_q[DIN0_LSB +: DW];
  assign sram.sram_web0   = web0Field;
  assign sram.sram_wmask0 = scanReg_q[WM0_LSB +: 4];
  assign sram.sram_addr1  = scanReg_q[ADDR1_LSB +: AW];
  assign sram.sram_din1   = scanReg_q[DIN1_LSB +: DW];
  assign sram.sram_web1   = web1Field;
  assign sram.sram_wmask1 = scanReg_q[WM1_LSB +: 4];
  assign sram.sram_csb0   = csb0Vec;
  assign sram.sram_csb1   = csb1Vec;

  // Per-macro chip selects. A macro is enabled only while the global strobe
  // is low, the port is enabled in the frame, and sel names that macro. When
  // sel is beyond the last macro, no bit matches and every select stays high.
  always_comb begin
    csb0Vec = '1;
    csb1Vec = '1;
    for (int k = 0; k < NUM_SRAMS; k++) begin
      csb0Vec[k] = (sel != SEL_W'(k)) | csb0Field | global_csb;
      csb1Vec[k] = (sel != SEL_W'(k)) | csb1Field | global_csb;
    end
  end

  // Read-data mux. It picks the macro that was selected on the launch edge.
  // A sel with no macro behind it returns zero.
  always_comb begin
    rdData0 = '0;
    rdData1 = '0;
    for (int k = 0; k < NUM_SRAMS; k++) begin
      if (sel_q == SEL_W'(k)) begin
        rdData0 = sram.sram_dout0[k*DW +: DW];
        rdData1 = sram.sram_dout1[k*DW +: DW];
      end
    end
  end

  // Scan register next state. A load takes priority over shifting, and it
  // only replaces the two din fields with the captured read data.
  always_comb begin
    scanReg_d = scanReg_q;
    if (sram_load) begin
      scanReg_d[DIN0_LSB +: DW] = dout0_q;
      scanReg_d[DIN1_LSB +: DW] = dout1_q;
    end else if (scan_en) begin
      scanReg_d = {scanReg_q[SR_W-2:0], scan_in};
    end
  end

  // State update. launched_q marks that the previous edge was a launch
  // edge, so the capture registers change only on the edge after a strobe
  // and hold otherwise. A write or a disabled port captures zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      scanReg_q  <= '0;
      launched_q <= 1'b0;
      rd0Pend_q  <= 1'b0;
      rd1Pend_q  <= 1'b0;
      sel_q      <= '0;
      dout0_q    <= '0;
      dout1_q    <= '0;
    end else begin
      scanReg_q  <= scanReg_d;
      launched_q <= ~global_csb;
      rd0Pend_q  <= ~global_csb & ~csb0Field & web0Field;
      rd1Pend_q  <= ~global_csb & ~csb1Field & web1Field;
      sel_q      <= sel;
      if (launched_q) begin
        dout0_q <= rd0Pend_q ? rdData0 : '0;
        dout1_q <= rd1Pend_q ? rdData1 : '0;
      end
    end
  end

endmodule

// File: tb/tb_openram_scan_sram_ctrl.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_openram_scan_sram_ctrl
//   Bench for the scan-chain SRAM controller. Macros 0..7 are dual-port and
//   macros 8..14 are single-port. Select value 15 has no macro behind it.
// ----------------------------------------------------------------------------
module tb_openram_scan_sram_ctrl;
  localparam int NSR = 15;
  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int FW  = 112;

  typedef struct packed {
    logic [3:0]  sel;
    logic [15:0] addr0;
    logic [31:0] din0;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [15:0] addr1;
    logic [31:0] din1;
    logic        csb1;
    logic        web1;
    logic [3:0]  wmask1;
  } frame_t;

  logic clock = 1'b0;
  logic reset, scan_en, scan_in, scan_out, sram_load, global_csb;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  openram_scan_sram_ctrl_if #(.NUM_SRAMS(NSR), .DW(DW), .AW(AW)) sramBus ();

  openram_scan_sram_ctrl #(.NUM_SRAMS(NSR), .DW(DW), .AW(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .scan_en    (scan_en),
    .scan_in    (scan_in),
    .scan_out   (scan_out),
    .sram_load  (sram_load),
    .global_csb (global_csb),
    .sram       (sramBus)
  );

  // Behavioural SRAM macros. Each one reads on its enable edge and presents
  // the data until its next read. Contents are cleared on reset.
  logic [31:0]        macMem   [NSR][256];
  logic [31:0]        macDout0 [NSR];
  logic [31:0]        macDout1 [NSR];
  logic [NSR*DW-1:0]  dout0Flat, dout1Flat;

  always_comb begin
    dout0Flat = '0;
    dout1Flat = '0;
    for (int k = 0; k < NSR; k++) begin
      dout0Flat[k*DW +: DW] = macDout0[k];
      dout1Flat[k*DW +: DW] = macDout1[k];
    end
  end
  assign sramBus.sram_dout0 = dout0Flat;
  assign sramBus.sram_dout1 = dout1Flat;

  always @(posedge clock) begin
    for (int k = 0; k < NSR; k++) begin
      if (reset) begin
        macDout0[k] <= '0;
        macDout1[k] <= '0;
        for (int a = 0; a < 256; a++) macMem[k][a] <= '0;
      end else begin
        if (!sramBus.sram_csb0[k]) begin
          if (!sramBus.sram_web0) begin
            for (int b = 0; b < 4; b++)
              if (sramBus.sram_wmask0[b])
                macMem[k][sramBus.sram_addr0[7:0]][b*8 +: 8] <= sramBus.sram_din0[b*8 +: 8];
          end else begin
            macDout0[k] <= macMem[k][sramBus.sram_addr0[7:0]];
          end
        end
        if (k < 8 && !sramBus.sram_csb1[k]) begin
          if (!sramBus.sram_web1) begin
            for (int b = 0; b < 4; b++)
              if (sramBus.sram_wmask1[b])
                macMem[k][sramBus.sram_addr1[7:0]][b*8 +: 8] <= sramBus.sram_din1[b*8 +: 8];
          end else begin
            macDout1[k] <= macMem[k][sramBus.sram_addr1[7:0]];
          end
        end
      end
    end
  end

  // Reference model. It tracks the expected register image, a golden memory
  // keyed by {sel, address}, and the read data that a load will deliver.
  frame_t      mdlReg, mF, mNxt;
  logic [31:0] mdlCap0, mdlCap1, mdlLaunch0, mdlLaunch1;
  logic        mdlLaunched;
  bit          mdlValid = 0;
  logic [31:0] goldMem [int];

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldW, input logic [31:0] newW,
                                             input logic [3:0] mask);
    logic [31:0] r;
    r = oldW;
    for (int b = 0; b < 4; b++) if (mask[b]) r[b*8 +: 8] = newW[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] goldRead(input int key);
    return goldMem.exists(key) ? goldMem[key] : 32'h0;
  endfunction

  always @(posedge clock) begin
    int key;
    if (reset) begin
      mdlReg      = '0;
      mdlCap0     = '0;
      mdlCap1     = '0;
      mdlLaunch0  = '0;
      mdlLaunch1  = '0;
      mdlLaunched = 1'b0;
      goldMem.delete();
      mdlValid    = 1;
    end else begin
      mF   = mdlReg;
      mNxt = mF;
      if (sram_load) begin
        mNxt.din0 = mdlCap0;
        mNxt.din1 = mdlCap1;
      end else if (scan_en) begin
        mNxt = {mdlReg[FW-2:0], scan_in};
      end
      if (mdlLaunched) begin
        mdlCap0 = mdlLaunch0;
        mdlCap1 = mdlLaunch1;
      end
      mdlLaunched = !global_csb;
      if (!global_csb) begin
        mdlLaunch0 = '0;
        mdlLaunch1 = '0;
        if (!mF.csb0 && int'(mF.sel) < NSR) begin
          key = int'(mF.sel) * 65536 + int'(mF.addr0);
          if (!mF.web0) goldMem[key] = mergeBytes(goldRead(key), mF.din0, mF.wmask0);
          else          mdlLaunch0   = goldRead(key);
        end
        if (!mF.csb1 && int'(mF.sel) < 8) begin
          key = int'(mF.sel) * 65536 + int'(mF.addr1);
          if (!mF.web1) goldMem[key] = mergeBytes(goldRead(key), mF.din1, mF.wmask1);
          else          mdlLaunch1   = goldRead(key);
        end
      end
      mdlReg = mNxt;
    end
  end

  task automatic checkOutput(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: actual %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model image.
  always @(negedge clock) begin
    frame_t f;
    logic [NSR-1:0] expCsb0, expCsb1;
    if (mdlValid) begin
      f = mdlReg;
      expCsb0 = '1;
      expCsb1 = '1;
      if (!global_csb && !f.csb0 && int'(f.sel) < NSR) expCsb0 = ~(NSR'(1) << f.sel);
      if (!global_csb && !f.csb1 && int'(f.sel) < NSR) expCsb1 = ~(NSR'(1) << f.sel);
      checkOutput("scan_out", FW'(scan_out), FW'(mdlReg[FW-1]));
      checkOutput("csb0", FW'(sramBus.sram_csb0), FW'(expCsb0));
      checkOutput("csb1", FW'(sramBus.sram_csb1), FW'(expCsb1));
      checkOutput("port0 bus",
                  FW'({sramBus.sram_addr0, sramBus.sram_din0, sramBus.sram_web0, sramBus.sram_wmask0}),
                  FW'({f.addr0, f.din0, f.web0, f.wmask0}));
      checkOutput("port1 bus",
                  FW'({sramBus.sram_addr1, sramBus.sram_din1, sramBus.sram_web1, sramBus.sram_wmask1}),
                  FW'({f.addr1, f.din1, f.web1, f.wmask1}));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Shift a full frame in MSB first while collecting the outgoing frame.
  task automatic applyStimulus(input frame_t fIn, output frame_t fOut);
    logic [FW-1:0] v, o;
    v = fIn;
    o = '0;
    for (int i = 0; i < FW; i++) begin
      o[FW-1-i] = scan_out;
      scan_en   = 1'b1;
      scan_in   = v[FW-1-i];
      tick();
    end
    scan_en = 1'b0;
    scan_in = 1'b0;
    fOut    = o;
  endtask

  task automatic strobeOnly();
    global_csb = 1'b0;
    tick();
    global_csb = 1'b1;
    tick();
  endtask

  task automatic strobeAndLoad();
    strobeOnly();
    sram_load = 1'b1;
    tick();
    sram_load = 1'b0;
  endtask

  frame_t wr, rd, got, junk, expF, pat;
  logic [FW-1:0] patBits;

  initial begin
    reset      = 1'b1;
    scan_en    = 1'b0;
    scan_in    = 1'b0;
    sram_load  = 1'b0;
    global_csb = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset scan_out", FW'(scan_out), FW'(1'b0));
    checkOutput("reset csb0", FW'(sramBus.sram_csb0), FW'(15'h7FFF));
    checkOutput("reset model image", FW'(mdlReg), FW'(0));

    // Dual-port macros: two writes through port 0, then read both ports.
    for (int i = 0; i < 7; i++) begin
      wr = '0;
      wr.sel = 4'(i);  wr.addr0 = 16'(16'h10 + i); wr.din0 = 32'(i);
      wr.csb0 = 1'b0;  wr.web0 = 1'b0; wr.wmask0 = 4'hF;
      wr.csb1 = 1'b1;  wr.web1 = 1'b1; wr.wmask1 = 4'hF;
      applyStimulus(wr, junk);
      strobeOnly();
      wr.addr0 = 16'(16'h40 + i); wr.din0 = 32'(i << 3);
      applyStimulus(wr, junk);
      strobeOnly();
      rd = '0;
      rd.sel = 4'(i);  rd.addr0 = 16'(16'h10 + i); rd.din0 = 32'hCAFE_0000;
      rd.csb0 = 1'b0;  rd.web0 = 1'b1; rd.wmask0 = 4'hF;
      rd.addr1 = 16'(16'h40 + i); rd.din1 = 32'h1234_5678;
      rd.csb1 = 1'b0;  rd.web1 = 1'b1; rd.wmask1 = 4'hF;
      applyStimulus(rd, junk);
      strobeAndLoad();
      checkOutput("model din0 pin", FW'(mdlReg.din0), FW'(i));
      applyStimulus('0, got);
      expF = rd;
      expF.din0 = 32'(i);
      expF.din1 = 32'(i << 3);
      checkOutput("dual-port readback", got, expF);
    end

    // Single-port macros: write DEADBEEF, read with port 1 disabled.
    for (int s = 8; s <= 10; s++) begin
      wr = '0;
      wr.sel = 4'(s);  wr.addr0 = 16'h0005; wr.din0 = 32'hDEAD_BEEF;
      wr.csb0 = 1'b0;  wr.web0 = 1'b0; wr.wmask0 = 4'hF;
      wr.csb1 = 1'b1;  wr.web1 = 1'b1; wr.wmask1 = 4'hF;
      applyStimulus(wr, junk);
      strobeOnly();
      rd = wr;
      rd.web0 = 1'b1;  rd.din0 = 32'h0; rd.din1 = 32'h0F0F_0F0F;
      applyStimulus(rd, junk);
      strobeAndLoad();
      applyStimulus('0, got);
      checkOutput("single-port din0", FW'(got.din0), FW'(32'hDEAD_BEEF));
      checkOutput("single-port din1", FW'(got.din1), FW'(0));
      checkOutput("single-port sel", FW'(got.sel), FW'(s));
      checkOutput("single-port wmask", FW'({got.wmask0, got.wmask1}), FW'(8'hFF));
    end

    // Load and shift in the same cycle: the load wins, nothing shifts.
    patBits = {32'h0123_4567, 32'h89AB_CDEF, 32'h1357_9BDF, 16'h2468};
    pat = patBits;
    applyStimulus(pat, junk);
    sram_load = 1'b1;
    scan_en   = 1'b1;
    scan_in   = 1'b1;
    tick();
    sram_load = 1'b0;
    scan_en   = 1'b0;
    scan_in   = 1'b0;
    applyStimulus('0, got);
    expF = pat;
    expF.din0 = 32'hDEAD_BEEF;
    expF.din1 = 32'h0;
    checkOutput("load beats shift", got, expF);

    // Shift only: the pattern returns unchanged and no select is asserted.
    patBits = {32'hF00D_1234, 32'h5A5A_A5A5, 32'h0BAD_CAFE, 16'h9E37};
    pat = patBits;
    applyStimulus(pat, junk);
    checkOutput("shift-only csb", FW'({sramBus.sram_csb0, sramBus.sram_csb1}), FW'(30'h3FFF_FFFF));
    applyStimulus('0, got);
    checkOutput("shift-only echo", got, pat);

    // Reset in the middle of a shift discards the partial frame.
    for (int i = 0; i < 50; i++) begin
      scan_en = 1'b1;
      scan_in = patBits[i];
      tick();
    end
    scan_en = 1'b0;
    reset   = 1'b1;
    tick();
    reset   = 1'b0;
    checkOutput("mid-shift reset scan_out", FW'(scan_out), FW'(1'b0));
    rd = '0;
    rd.sel = 4'd15;  rd.addr0 = 16'h0003; rd.din0 = 32'hFFFF_0000;
    rd.csb0 = 1'b0;  rd.web0 = 1'b1; rd.wmask0 = 4'hF;
    rd.addr1 = 16'h0003; rd.din1 = 32'h0000_FFFF;
    rd.csb1 = 1'b0;  rd.web1 = 1'b1; rd.wmask1 = 4'hF;
    applyStimulus(rd, junk);
    checkOutput("discarded frame", junk, FW'(0));
    global_csb = 1'b0;
    #1;
    checkOutput("sel15 csb", FW'({sramBus.sram_csb0, sramBus.sram_csb1}), FW'(30'h3FFF_FFFF));
    tick();
    global_csb = 1'b1;
    tick();
    sram_load = 1'b1;
    tick();
    sram_load = 1'b0;
    applyStimulus('0, got);
    expF = rd;
    expF.din0 = 32'h0;
    expF.din1 = 32'h0;
    checkOutput("sel15 readback", got, expF);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
